// File: rtl/spc7110_rom_arbiter_if.sv
// rtl/spc7110_rom_arbiter_if.sv - requester and memory-controller signals of the SPC7110 ROM read-port arbiter
interface spc7110_rom_arbiter_if;
   logic        snes_req;
   logic [23:0] snes_raddr;
   logic [7:0]  snes_rdata;
   logic        snes_ack;
   logic        dcu_req;
   logic [23:0] dcu_raddr;
   logic [7:0]  dcu_rdata;
   logic        dcu_ack;
   logic        dp_req;
   logic [23:0] dp_raddr;
   logic [7:0]  dp_rdata;
   logic        dp_ack;
   logic [23:0] mem_addr;
   logic        mem_oe;
   logic [7:0]  mem_rdata;
   logic        busy;

   modport slave (
      input  snes_req, snes_raddr, dcu_req, dcu_raddr, dp_req, dp_raddr, mem_rdata,
      output snes_rdata, snes_ack, dcu_rdata, dcu_ack, dp_rdata, dp_ack,
             mem_addr, mem_oe, busy
   );

   modport master (
      output snes_req, snes_raddr, dcu_req, dcu_raddr, dp_req, dp_raddr, mem_rdata,
      input  snes_rdata, snes_ack, dcu_rdata, dcu_ack, dp_rdata, dp_ack,
             mem_addr, mem_oe, busy
   );
endinterface

// File: rtl/spc7110_rom_arbiter.sv
// rtl/spc7110_rom_arbiter.sv - shares the ROM read port among SNES, DCU and data port
// Optional one-entry data-port byte cache enabled by defining SPC7110_DP_CACHE_EN.
module spc7110_rom_arbiter #(
   parameter int unsigned RD_CYCLES = 4,
   parameter bit          RR_RESET  = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   spc7110_rom_arbiter_if.slave        bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   typedef enum logic [1:0] {W_SNES, W_DCU, W_DP} win_t;

   state_t      state;
   win_t        winner;
   win_t        pick;
   logic        rr_last_dp;
   logic [3:0]  cnt;
   logic        any_req;
   logic        hit;
   logic [23:0] pick_addr;

   // SNES always wins; DCU/DP alternate, favouring whichever was not served last
   always_comb begin
      any_req = bus.snes_req | bus.dcu_req | bus.dp_req;
      if (bus.snes_req)                    pick = W_SNES;
      else if (bus.dcu_req && bus.dp_req)  pick = rr_last_dp ? W_DCU : W_DP;
      else if (bus.dcu_req)                pick = W_DCU;
      else                                 pick = W_DP;
      case (pick)
         W_SNES:  pick_addr = bus.snes_raddr;
         W_DCU:   pick_addr = bus.dcu_raddr;
         default: pick_addr = bus.dp_raddr;
      endcase
   end

`ifdef SPC7110_DP_CACHE_EN
   logic [23:0] tag;
   logic        tag_valid;

   assign hit = tag_valid && (pick == W_DP) && (bus.dp_raddr == tag);

   // Any memory access other than a DP fill invalidates; the byte itself lives in dp_rdata
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag       <= '0;
         tag_valid <= 1'b0;
      end else if (state == IDLE && any_req && !hit) begin
         tag_valid <= 1'b0;
         if (pick == W_DP) tag <= bus.dp_raddr;
      end else if (state == ACCESS && cnt == 4'd0 && winner == W_DP) begin
         tag_valid <= 1'b1;
      end
   end
`else
   assign hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         winner         <= W_SNES;
         rr_last_dp     <= RR_RESET;
         cnt            <= '0;
         bus.mem_addr   <= '0;
         bus.mem_oe     <= 1'b0;
         bus.busy       <= 1'b0;
         bus.snes_ack   <= 1'b0;
         bus.dcu_ack    <= 1'b0;
         bus.dp_ack     <= 1'b0;
         bus.snes_rdata <= '0;
         bus.dcu_rdata  <= '0;
         bus.dp_rdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  winner   <= pick;
                  bus.busy <= 1'b1;
                  if (hit) begin
                     bus.dp_ack <= 1'b1;
                     state      <= DONE;
                  end else begin
                     bus.mem_addr <= pick_addr;
                     bus.mem_oe   <= 1'b1;
                     cnt          <= 4'(RD_CYCLES - 1);
                     state        <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (cnt == 4'd0) begin
                  case (winner)
                     W_SNES: begin bus.snes_rdata <= bus.mem_rdata; bus.snes_ack <= 1'b1; end
                     W_DCU:  begin bus.dcu_rdata  <= bus.mem_rdata; bus.dcu_ack  <= 1'b1; end
                     default: begin bus.dp_rdata  <= bus.mem_rdata; bus.dp_ack   <= 1'b1; end
                  endcase
                  bus.mem_oe <= 1'b0;
                  state      <= DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: begin
               bus.snes_ack <= 1'b0;
               bus.dcu_ack  <= 1'b0;
               bus.dp_ack   <= 1'b0;
               bus.busy     <= 1'b0;
               if (winner == W_DCU)     rr_last_dp <= 1'b0;
               else if (winner == W_DP) rr_last_dp <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_spc7110_rom_arbiter.sv
// tb/tb_spc7110_rom_arbiter.sv - directed vector bench for spc7110_rom_arbiter
module tb_spc7110_rom_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   logic rst1_n;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   spc7110_rom_arbiter_if bif ();
   spc7110_rom_arbiter_if bif1 ();

   spc7110_rom_arbiter #(.RD_CYCLES(4), .RR_RESET(1'b1)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bif.slave));
   spc7110_rom_arbiter #(.RD_CYCLES(1), .RR_RESET(1'b1)) u_dut1 (.clk(clk), .rst_n(rst1_n), .bus(bif1.slave));

   function automatic logic [7:0] mem_byte(input logic [23:0] a);
      if (a == 24'h123456) return 8'hA5;
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   assign bif.mem_rdata  = mem_byte(bif.mem_addr);
   assign bif1.mem_rdata = mem_byte(bif1.mem_addr);

`ifdef SPC7110_DP_CACHE_EN
   localparam int HIT_LAT = 1;
   localparam int HIT_OE  = 0;
`else
   localparam int HIT_LAT = 5;
   localparam int HIT_OE  = 4;
`endif

   typedef struct {
      logic        snes, dcu, dp;
      logic [23:0] sa, ca, pa;
      logic [2:0]  exp_ack;
      logic [23:0] exp_addr;
      int          exp_lat;
      int          exp_oe;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_ack(input bit sel, input int bound, output logic [2:0] acks, output int lat,
                           output int oe_n, output logic [23:0] oe_addr, output bit addr_moved);
      logic        oe;
      logic [23:0] a;
      acks = '0; lat = 0; oe_n = 0; oe_addr = '0; addr_moved = 1'b0;
      while (acks == 3'b000 && lat < bound) begin
         @(negedge clk);
         lat++;
         oe = sel ? bif1.mem_oe : bif.mem_oe;
         a  = sel ? bif1.mem_addr : bif.mem_addr;
         if (oe) begin
            if (oe_n > 0 && a != oe_addr) addr_moved = 1'b1;
            oe_n++;
            oe_addr = a;
         end
         acks = sel ? {bif1.snes_ack, bif1.dcu_ack, bif1.dp_ack} : {bif.snes_ack, bif.dcu_ack, bif.dp_ack};
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vt[9];
      logic [7:0]  shadow[3];
      logic [2:0]  acks;
      logic [2:0]  seq[4];
      int          lat, oe_n, idx;
      logic [23:0] oe_addr;
      bit          moved;

      vt[0] = '{1'b1, 1'b0, 1'b0, 24'h123456, 24'h0, 24'h0, 3'b100, 24'h123456, 5, 4};
      vt[1] = '{1'b0, 1'b1, 1'b0, 24'h0, 24'h010203, 24'h0, 3'b010, 24'h010203, 5, 4};
      vt[2] = '{1'b0, 1'b0, 1'b1, 24'h0, 24'h0, 24'h200000, 3'b001, 24'h200000, 5, 4};
      vt[3] = '{1'b1, 1'b1, 1'b1, 24'h000300, 24'h040404, 24'h200000, 3'b100, 24'h000300, 5, 4};
      vt[4] = '{1'b0, 1'b1, 1'b1, 24'h0, 24'h050505, 24'h200010, 3'b010, 24'h050505, 5, 4};
      vt[5] = '{1'b0, 1'b1, 1'b1, 24'h0, 24'h060606, 24'h200000, 3'b001, 24'h200000, 5, 4};
      vt[6] = '{1'b0, 1'b0, 1'b1, 24'h0, 24'h0, 24'h200000, 3'b001, 24'h200000, HIT_LAT, HIT_OE};
      vt[7] = '{1'b0, 1'b1, 1'b0, 24'h0, 24'h000010, 24'h0, 3'b010, 24'h000010, 5, 4};
      vt[8] = '{1'b0, 1'b0, 1'b1, 24'h0, 24'h0, 24'h200000, 3'b001, 24'h200000, 5, 4};
      shadow[0] = 8'h00; shadow[1] = 8'h00; shadow[2] = 8'h00;

      rst_n = 1'b0; rst1_n = 1'b0;
      bif.snes_req = 0; bif.dcu_req = 0; bif.dp_req = 0;
      bif.snes_raddr = 0; bif.dcu_raddr = 0; bif.dp_raddr = 0;
      bif1.snes_req = 0; bif1.dcu_req = 0; bif1.dp_req = 0;
      bif1.snes_raddr = 0; bif1.dcu_raddr = 0; bif1.dp_raddr = 0;
      repeat (3) @(negedge clk);
      chk("reset_oe", 32'(bif.mem_oe), 0);
      chk("reset_busy", 32'(bif.busy), 0);
      chk("reset_acks", 32'({bif.snes_ack, bif.dcu_ack, bif.dp_ack}), 0);
      chk("reset_addr", 32'(bif.mem_addr), 0);
      chk("reset_rdata", 32'({bif.snes_rdata, bif.dcu_rdata, bif.dp_rdata}), 0);
      rst_n = 1'b1; rst1_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         chk($sformatf("v%0d_idle_busy", i), 32'(bif.busy), 0);
         bif.snes_req = vt[i].snes; bif.dcu_req = vt[i].dcu; bif.dp_req = vt[i].dp;
         bif.snes_raddr = vt[i].sa; bif.dcu_raddr = vt[i].ca; bif.dp_raddr = vt[i].pa;
         wait_ack(1'b0, 20, acks, lat, oe_n, oe_addr, moved);
         bif.snes_req = 0; bif.dcu_req = 0; bif.dp_req = 0;
         chk($sformatf("v%0d_ack", i), 32'(acks), 32'(vt[i].exp_ack));
         chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].exp_lat));
         chk($sformatf("v%0d_oe_cycles", i), 32'(oe_n), 32'(vt[i].exp_oe));
         chk($sformatf("v%0d_busy", i), 32'(bif.busy), 1);
         if (vt[i].exp_oe > 0) begin
            chk($sformatf("v%0d_addr", i), 32'(oe_addr), 32'(vt[i].exp_addr));
            chk($sformatf("v%0d_addr_stable", i), 32'(moved), 0);
         end
         idx = vt[i].exp_ack[2] ? 0 : (vt[i].exp_ack[1] ? 1 : 2);
         shadow[idx] = mem_byte(vt[i].exp_addr);
         chk($sformatf("v%0d_snes_rdata", i), 32'(bif.snes_rdata), 32'(shadow[0]));
         chk($sformatf("v%0d_dcu_rdata", i), 32'(bif.dcu_rdata), 32'(shadow[1]));
         chk($sformatf("v%0d_dp_rdata", i), 32'(bif.dp_rdata), 32'(shadow[2]));
      end

      // SNES and DCU raised while a DP read is in flight; DP address moves mid-access
      @(negedge clk);
      bif.dp_req = 1; bif.dp_raddr = 24'h200080;
      @(negedge clk);
      @(negedge clk);
      bif.snes_req = 1; bif.snes_raddr = 24'h000200;
      bif.dcu_req = 1;  bif.dcu_raddr = 24'h030000;
      bif.dp_raddr = 24'h2000FF;
      wait_ack(1'b0, 20, acks, lat, oe_n, oe_addr, moved);
      bif.dp_req = 0;
      chk("mid_dp_ack", 32'(acks), 32'(3'b001));
      chk("mid_dp_addr", 32'(oe_addr), 32'h200080);
      chk("mid_dp_rdata", 32'(bif.dp_rdata), 32'(mem_byte(24'h200080)));
      wait_ack(1'b0, 20, acks, lat, oe_n, oe_addr, moved);
      bif.snes_req = 0;
      chk("mid_snes_first", 32'(acks), 32'(3'b100));
      chk("mid_snes_rdata", 32'(bif.snes_rdata), 32'(mem_byte(24'h000200)));
      wait_ack(1'b0, 20, acks, lat, oe_n, oe_addr, moved);
      bif.dcu_req = 0;
      chk("mid_dcu_second", 32'(acks), 32'(3'b010));
      chk("mid_dcu_rdata", 32'(bif.dcu_rdata), 32'(mem_byte(24'h030000)));
      chk("mid_dp_unchanged", 32'(bif.dp_rdata), 32'(mem_byte(24'h200080)));

      // Reset on the second ACCESS clock, then DCU/DP alternation from reset
      @(negedge clk);
      bif.snes_req = 1; bif.snes_raddr = 24'h000100;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      bif.snes_req = 0;
      #1;
      chk("rst_mid_oe", 32'(bif.mem_oe), 0);
      chk("rst_mid_busy", 32'(bif.busy), 0);
      chk("rst_mid_acks", 32'({bif.snes_ack, bif.dcu_ack, bif.dp_ack}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bif.dcu_req = 1; bif.dcu_raddr = 24'h040000;
      bif.dp_req = 1;  bif.dp_raddr = 24'h200040;
      seq[0] = 3'b010; seq[1] = 3'b001; seq[2] = 3'b010; seq[3] = 3'b001;
      for (int k = 0; k < 4; k++) begin
         wait_ack(1'b0, 20, acks, lat, oe_n, oe_addr, moved);
         chk($sformatf("alt%0d_ack", k), 32'(acks), 32'(seq[k]));
         @(negedge clk);
         chk($sformatf("alt%0d_ack_pulse", k), 32'({bif.snes_ack, bif.dcu_ack, bif.dp_ack}), 0);
      end
      bif.dcu_req = 0; bif.dp_req = 0;

      // RD_CYCLES=1 instance with SNES held high
      @(negedge clk);
      bif1.snes_req = 1; bif1.snes_raddr = 24'h000055;
      for (int k = 0; k < 3; k++) begin
         wait_ack(1'b1, 20, acks, lat, oe_n, oe_addr, moved);
         chk($sformatf("rd1_%0d_ack", k), 32'(acks), 32'(3'b100));
         chk($sformatf("rd1_%0d_lat", k), 32'(lat), (k == 0) ? 32'd2 : 32'd3);
         chk($sformatf("rd1_%0d_oe", k), 32'(oe_n), 1);
      end
      bif1.snes_req = 0;
      chk("rd1_rdata", 32'(bif1.snes_rdata), 32'(mem_byte(24'h000055)));
      @(negedge clk);
      chk("rd1_ack_pulse", 32'(bif1.snes_ack), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/spc7110_rom_arbiter.md
Name: spc7110_rom_arbiter

Overview:
Shares the single ROM read port (SRAM0) among three requesters: SNES bus reads, the SPC7110 decompression unit (DCU) fetch engine, and the SPC7110 direct data port at $4810.
- All three present already-mapped 24-bit ROM addresses, i.e. after PROM/DROM bank translation and ROM masking.
- The block sequences one ROM read at a time and returns each byte with a per-requester acknowledge.
- It sits between the address decode/mapping logic and the memory controller.

Parameters:
RD_CYCLES, 4, number of clocks MEM_OE is held per access (memory read latency); legal range 1-15.
RR_RESET, 1, reset value of the round-robin flag (1 = DP was served last, so DCU wins the first tie).

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
SNES_REQ  in  1  SNES read request, level, held until SNES_ACK
SNES_RADDR  in  24  SNES mapped ROM address, stable while SNES_REQ
SNES_RDATA  out  8  byte for SNES, valid with SNES_ACK, held until next SNES_ACK
SNES_ACK  out  1  one-cycle completion pulse
DCU_REQ  in  1  DCU fetch request, level
DCU_RADDR  in  24  DCU ROM address
DCU_RDATA  out  8  byte for DCU
DCU_ACK  out  1  one-cycle completion pulse
DP_REQ  in  1  data-port read request, level
DP_RADDR  in  24  data-port ROM address
DP_RDATA  out  8  byte for data port
DP_ACK  out  1  one-cycle completion pulse
MEM_ADDR  out  24  address to memory controller
MEM_OE  out  1  read strobe to memory controller
MEM_RDATA  in  8  memory read data
BUSY  out  1  high in any state other than IDLE

Behaviour:
Reset:
- All outputs are 0; state is IDLE; round-robin flag = RR_RESET; counter = 0.
- Asserting reset mid-access aborts the in-flight read; no ACK is issued for it.

FSM states: IDLE, ACCESS, DONE.

IDLE:
- Requests are sampled on every edge.
- Priority: SNES is fixed highest. DCU and DP are round-robin between themselves, and the winner is the one not served last.
- On a grant: latch the winner id, register MEM_ADDR from the winner's address, set MEM_OE = 1, load counter = RD_CYCLES-1, go to ACCESS.

ACCESS:
- MEM_OE stays high and MEM_ADDR stays constant.
- The counter decrements each clock.
- On the edge where counter == 0: capture MEM_RDATA into the winner's RDATA register, drop MEM_OE, go to DONE.

DONE:
- Winner's ACK = 1 for exactly this cycle.
- If the winner is DCU or DP, update the round-robin flag.
- Return to IDLE next edge.

Timing and handshake:
- Grant edge to ACK: RD_CYCLES+1 clocks. Back-to-back throughput is one access per RD_CYCLES+2 clocks.
- No preemption: a SNES_REQ that rises during ACCESS waits and is served first at the next IDLE, ahead of any pending DCU/DP.
- A requester's REQ still high in the IDLE cycle after its ACK is treated as a new request.
- Addresses are sampled only at grant; address changes during ACCESS are ignored.
- RDATA registers of non-winners are never modified.
- Simultaneous DCU_REQ and DP_REQ with no SNES_REQ: the round-robin flag decides.
- With a single requester active, it is served repeatedly with no idle gaps beyond the DONE→IDLE cycle.

Optional Feature:
Macro SPC7110_DP_CACHE_EN.
- With it: a one-entry tag (24-bit address plus valid bit) holds the last DP byte fetched.
- On a DP grant in IDLE whose DP_RADDR equals the tag with valid = 1:
  - no memory access; MEM_OE stays 0;
  - go directly to DONE and issue DP_ACK with the cached byte, so latency is 1 clock;
  - this still counts as a DP service for round-robin.
- Any DCU access or SNES access clears valid (conservative coherency). Reset clears valid.
- Without it: every DP request performs a full memory access.

Test Plan:
- RD_CYCLES=4; SNES_REQ with addr 0x123456, MEM_RDATA=0xA5 → MEM_OE high for 4 clocks with MEM_ADDR=0x123456; SNES_ACK exactly 5 clocks after the grant edge; SNES_RDATA=0xA5.
- DCU_REQ and DP_REQ both held high from reset → grants alternate DCU, DP, DCU, DP; each ACK is a single cycle.
- DP access in ACCESS; SNES_REQ and DCU_REQ raised mid-access → SNES is granted next, then DCU; DP_RDATA is unchanged by those accesses.
- Reset asserted on the 2nd ACCESS clock → MEM_OE=0, BUSY=0 and all ACKs 0 immediately; after release, the first grant goes to DCU when both DCU and DP request (RR_RESET=1).
- SPC7110_DP_CACHE_EN: DP reads 0x200000 twice with no intervening access → second DP_ACK one clock after grant, no MEM_OE. Then a DCU read followed by a DP read of 0x200000 → full 5-clock access.
- RD_CYCLES=1 → MEM_OE is a single-clock pulse; ACK 2 clocks after grant; back-to-back SNES requests produce an ACK every 3 clocks.
